button_gesture: RTL

- Sits directly downstream of the per-button debouncers on the debug front panel.
- Turns two debounced button levels into one-cycle event pulses: click, double-click, long-press and chord (both buttons held).
- The pulses drive the click mux advance, the debug reset request and future mode selection.
- It replaces ad-hoc level decoding such as AND-ing both buttons for reset.

---
 rtl/button_gesture_pkg.sv | 14 +
 rtl/gesture_channel.sv | 84 ++++++++
 rtl/button_gesture.sv | 72 +++++++
 3 files changed

// File: rtl/button_gesture_pkg.sv
// Shared types and sizing helper for the button gesture decoder.
package button_gesture_pkg;

   typedef enum logic [1:0] {IDLE, PRESS, WAIT, HELD} gesture_state_t;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/gesture_channel.sv
// One button channel: edge detect, gesture FSM and its click/long/double pulses.
module gesture_channel
   import button_gesture_pkg::*;
#(
   parameter int LONG_CYCLES = 50_000_000,
   parameter int DBL_CYCLES  = 12_500_000,
   parameter int CNT_W       = 27
) (
   input  logic           clk,
   input  logic           i_reset,
   input  logic           button,
   input  logic           force_held,
   output logic           click_pulse,
   output logic           double_pulse,
   output logic           long_pulse,
   output gesture_state_t state
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             prev;
   logic             rise;

   assign rise = button & ~prev;

   // prev resets high so a button held through reset must be released first.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state        <= IDLE;
         cnt          <= '0;
         prev         <= 1'b1;
         click_pulse  <= 1'b0;
         double_pulse <= 1'b0;
         long_pulse   <= 1'b0;
      end else begin
         prev         <= button;
         click_pulse  <= 1'b0;
         double_pulse <= 1'b0;
         long_pulse   <= 1'b0;
         if (force_held) begin
            state <= HELD;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     state <= PRESS;
                     cnt   <= '0;
                  end
               end
               PRESS: begin
                  if (!button) begin
                     state <= WAIT;
                     cnt   <= '0;
                  end else if (cnt == LONG_LAST) begin
                     state      <= HELD;
                     long_pulse <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               WAIT: begin
                  if (rise) begin
                     state        <= HELD;
                     double_pulse <= 1'b1;
                  end else if (cnt == DBL_LAST) begin
                     state       <= IDLE;
                     click_pulse <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               HELD: begin
                  if (!button) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/button_gesture.sv
// Turns debounced button levels into click/double/long pulses per channel plus a two-button chord pulse.
module button_gesture
   import button_gesture_pkg::*;
#(
   parameter int N_BUTTONS    = 2,
   parameter int LONG_CYCLES  = 50_000_000,
   parameter int DBL_CYCLES   = 12_500_000,
   parameter int CHORD_CYCLES = 1_000_000
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic [N_BUTTONS-1:0] i_buttons,
   output logic [N_BUTTONS-1:0] o_click,
   output logic [N_BUTTONS-1:0] o_double,
   output logic [N_BUTTONS-1:0] o_long,
   output logic                 o_chord,
   output logic [N_BUTTONS-1:0] o_busy
);

   localparam int CNT_W = cnt_width(LONG_CYCLES, DBL_CYCLES, CHORD_CYCLES);
   localparam logic [CNT_W-1:0] CHORD_LAST = CNT_W'(CHORD_CYCLES - 1);

   logic             both_now;
   logic             both_q;
   logic             chord_latch;
   logic [CNT_W-1:0] chord_cnt;
   gesture_state_t   ch_state [N_BUTTONS];

   assign both_now = i_buttons[0] & i_buttons[1];

   for (genvar b = 0; b < N_BUTTONS; b++) begin : g_ch
      localparam bit CHORD_CH = (b < 2);
      gesture_channel #(
         .LONG_CYCLES (LONG_CYCLES),
         .DBL_CYCLES  (DBL_CYCLES),
         .CNT_W       (CNT_W)
      ) u_ch (
         .clk          (clk),
         .i_reset      (i_reset),
         .button       (i_buttons[b]),
         .force_held   (CHORD_CH & both_now),
         .click_pulse  (o_click[b]),
         .double_pulse (o_double[b]),
         .long_pulse   (o_long[b]),
         .state        (ch_state[b])
      );
      assign o_busy[b] = (ch_state[b] != IDLE);
   end

   // Chord counts on the registered both-held level so it lines up with channel pulse timing.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         both_q      <= 1'b0;
         chord_cnt   <= '0;
         chord_latch <= 1'b0;
         o_chord     <= 1'b0;
      end else begin
         both_q  <= both_now;
         o_chord <= 1'b0;
         if (!both_q) begin
            chord_cnt <= '0;
         end else if (chord_cnt != CHORD_LAST) begin
            chord_cnt <= chord_cnt + 1'b1;
         end else if (!chord_latch) begin
            o_chord     <= 1'b1;
            chord_latch <= 1'b1;
         end
         if (i_buttons[1:0] == 2'b00) chord_latch <= 1'b0;
      end
   end

endmodule
